// File: rtl/flow_frame_sequencer_if.sv
// Pixel, flow-vector and datapath handshake bundle for flow_frame_sequencer.
// master: the sequencer side; slave: the surrounding system (source, datapath, sink).
interface flow_frame_sequencer_if;
    logic [7:0]  recv_pix;
    logic        recv_pix_val;
    logic        recv_pix_rdy;

    logic [7:0]  send_curr;
    logic        send_curr_val;
    logic        send_curr_rdy;
    logic [7:0]  send_prev;
    logic        send_prev_val;
    logic        send_prev_rdy;

    logic [63:0] recv_uv;
    logic        recv_uv_val;
    logic        recv_uv_rdy;

    logic [63:0] send_uv;
    logic        send_uv_val;
    logic        send_uv_rdy;
    logic        send_uv_last;

    modport master (
        input  recv_pix, recv_pix_val,
        output recv_pix_rdy,
        output send_curr, send_curr_val,
        input  send_curr_rdy,
        output send_prev, send_prev_val,
        input  send_prev_rdy,
        input  recv_uv, recv_uv_val,
        output recv_uv_rdy,
        output send_uv, send_uv_val, send_uv_last,
        input  send_uv_rdy
    );

    modport slave (
        output recv_pix, recv_pix_val,
        input  recv_pix_rdy,
        input  send_curr, send_curr_val,
        output send_curr_rdy,
        input  send_prev, send_prev_val,
        output send_prev_rdy,
        output recv_uv, recv_uv_val,
        input  recv_uv_rdy,
        input  send_uv, send_uv_val, send_uv_last,
        output send_uv_rdy
    );
endinterface

// File: rtl/flow_frame_sequencer.sv
// Ping-pong frame buffer that streams current/previous frame pairs into the
// optical-flow datapath and counts the returned flow vectors per frame.
//
// state  | meaning
// LOAD   | accepting pixels into bank[wr_bank]
// STREAM | sending bank[wr_bank] (curr) and bank[!wr_bank] (prev) in lockstep
// DRAIN  | waiting for the remaining flow vectors or the drain timeout
module flow_frame_sequencer #(
    parameter int WIDTH         = 64,
    parameter int HEIGHT        = 64,
    parameter int EXP_UV        = 3968,
    parameter int DRAIN_TIMEOUT = 1024
) (
    input  logic                   clk,
    input  logic                   reset,
    flow_frame_sequencer_if.master io,
    output logic                   frame_done,
    output logic [15:0]            frame_cnt,
    output logic                   busy,
    output logic                   err
);
    localparam int NPIX = WIDTH * HEIGHT;
    localparam int AW   = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam logic [AW-1:0] LAST_ADDR = AW'(NPIX - 1);
    localparam logic [15:0]   UV_FULL   = 16'(EXP_UV);
    localparam logic [15:0]   UV_LAST   = 16'(EXP_UV - 1);
    localparam logic [15:0]   TO_LAST   = 16'(DRAIN_TIMEOUT - 1);

    typedef enum logic [1:0] {LOAD, STREAM, DRAIN} state_t;

    state_t          state, state_nx;
    logic [7:0]      bank [2][NPIX];
    logic            wr_bank, wr_bank_nx;
    logic            have_prev, have_prev_nx;
    logic [AW-1:0]   wr_addr, wr_addr_nx;
    logic [AW-1:0]   rd_addr, rd_addr_nx;
    logic [15:0]     uv_cnt, uv_cnt_nx;
    logic [15:0]     to_cnt, to_cnt_nx;
    logic [15:0]     frame_cnt_nx;
    logic            err_nx;
    logic            frame_done_nx;

    logic pix_acc, xfer, uv_hs, uv_full;

    assign busy    = (state != LOAD);
    assign uv_full = (uv_cnt == UV_FULL);
    assign uv_hs   = io.recv_uv_val && io.send_uv_rdy;

    assign io.recv_pix_rdy  = (state == LOAD) && !reset;
    assign pix_acc          = io.recv_pix_val && io.recv_pix_rdy;

    assign io.send_curr     = bank[wr_bank][rd_addr];
    assign io.send_prev     = bank[~wr_bank][rd_addr];
    assign io.send_curr_val = (state == STREAM);
    assign io.send_prev_val = (state == STREAM);
    assign xfer             = (state == STREAM) && io.send_curr_rdy && io.send_prev_rdy;

    // Flow vectors pass straight through; the sequencer only observes them.
    assign io.send_uv      = io.recv_uv;
    assign io.send_uv_val  = io.recv_uv_val;
    assign io.recv_uv_rdy  = io.send_uv_rdy;
    assign io.send_uv_last = io.recv_uv_val && busy && (uv_cnt == UV_LAST);

    always_ff @(posedge clk) begin
        if (pix_acc) begin
            bank[wr_bank][wr_addr] <= io.recv_pix;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= LOAD;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx     = state;
        wr_bank_nx   = wr_bank;
        have_prev_nx = have_prev;
        wr_addr_nx   = wr_addr;
        rd_addr_nx   = rd_addr;
        uv_cnt_nx    = uv_cnt;
        to_cnt_nx    = to_cnt;
        frame_cnt_nx = frame_cnt;
        err_nx       = err;

        case (state)
            LOAD: begin
                if (pix_acc) begin
                    wr_addr_nx = wr_addr + AW'(1);
                    if (wr_addr == LAST_ADDR) begin
                        wr_addr_nx = '0;
                        if (!have_prev) begin
                            have_prev_nx = 1'b1;
                            wr_bank_nx   = ~wr_bank;
                        end else begin
                            rd_addr_nx = '0;
                            uv_cnt_nx  = '0;
                            state_nx   = STREAM;
                        end
                    end
                end
            end
            STREAM: begin
                if (xfer) begin
                    rd_addr_nx = rd_addr + AW'(1);
                    if (rd_addr == LAST_ADDR) begin
                        to_cnt_nx = '0;
                        state_nx  = DRAIN;
                    end
                end
            end
            DRAIN: begin
                to_cnt_nx = to_cnt + 16'd1;
                if (uv_full || to_cnt == TO_LAST) begin
                    // Flip banks so the next frame overwrites the older one.
                    state_nx     = LOAD;
                    frame_cnt_nx = frame_cnt + 16'd1;
                    wr_bank_nx   = ~wr_bank;
                    if (!uv_full) err_nx = 1'b1;
                end
            end
            default: state_nx = LOAD;
        endcase

        if (busy && uv_hs && !uv_full) uv_cnt_nx = uv_cnt + 16'd1;
        if (uv_hs && (!busy || uv_full)) err_nx = 1'b1;

        // Registered pulse lands in the DRAIN cycle that exits.
        frame_done_nx = (state_nx == DRAIN) &&
                        ((uv_cnt_nx == UV_FULL) || (to_cnt_nx == TO_LAST));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_bank    <= 1'b0;
            have_prev  <= 1'b0;
            wr_addr    <= '0;
            rd_addr    <= '0;
            uv_cnt     <= '0;
            to_cnt     <= '0;
            frame_cnt  <= '0;
            err        <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            wr_bank    <= wr_bank_nx;
            have_prev  <= have_prev_nx;
            wr_addr    <= wr_addr_nx;
            rd_addr    <= rd_addr_nx;
            uv_cnt     <= uv_cnt_nx;
            to_cnt     <= to_cnt_nx;
            frame_cnt  <= frame_cnt_nx;
            err        <= err_nx;
            frame_done <= frame_done_nx;
        end
    end
endmodule

// File: tb/tb_flow_frame_sequencer.sv
// Bench for flow_frame_sequencer: frame-pair model plus directed scenarios
// for normal frames, backpressure, drain timeout, stray vectors and reset.
module tb_flow_frame_sequencer;
    localparam int W      = 4;
    localparam int H      = 4;
    localparam int NPIX   = W * H;
    localparam int EXP_UV = 8;
    localparam int DTO    = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        frame_done;
    logic [15:0] frame_cnt;
    logic        busy;
    logic        err;

    flow_frame_sequencer_if bus();

    flow_frame_sequencer #(
        .WIDTH(W), .HEIGHT(H), .EXP_UV(EXP_UV), .DRAIN_TIMEOUT(DTO)
    ) dut (
        .clk(clk), .reset(reset), .io(bus),
        .frame_done(frame_done), .frame_cnt(frame_cnt), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Model: whole frames as they are accepted, and the pixel pairs each new
    // frame must produce together with the frame before it.
    typedef struct { logic [7:0] c; logic [7:0] p; } pair_t;
    pair_t      pq[$];
    logic [7:0] cur_buf [NPIX];
    logic [7:0] prev_frame [NPIX];
    int         cur_n = 0;
    bit         m_have_prev = 1'b0;
    int         drain_cyc = 0;
    bit         rand_en = 1'b0;

    always @(negedge clk) begin
        check_eq("uv_fwd_data", bus.send_uv, bus.recv_uv);
        check_eq("uv_fwd_val", bus.send_uv_val, bus.recv_uv_val);
        check_eq("uv_fwd_rdy", bus.recv_uv_rdy, bus.send_uv_rdy);
        if (reset) begin
            check_eq("pix_rdy_in_reset", bus.recv_pix_rdy, 1'b0);
            cur_n = 0;
            m_have_prev = 1'b0;
            pq.delete();
        end else begin
            check_eq("pix_rdy_vs_busy", bus.recv_pix_rdy, !busy);
            check_eq("val_lockstep", bus.send_prev_val, bus.send_curr_val);
            if (pq.size() != 0) check_eq("pix_rdy_while_pending", bus.recv_pix_rdy, 1'b0);
            if (frame_done) check_eq("done_with_pixels_pending", pq.size(), 0);
            if (bus.send_curr_val) begin
                drain_cyc = 0;
                if (pq.size() == 0) begin
                    check_eq("unexpected_stream", bus.send_curr_val, 1'b0);
                end else begin
                    check_eq("send_curr", bus.send_curr, pq[0].c);
                    check_eq("send_prev", bus.send_prev, pq[0].p);
                    if (bus.send_curr_rdy && bus.send_prev_rdy) void'(pq.pop_front());
                end
            end else if (busy) begin
                drain_cyc++;
            end
            if (bus.recv_pix_val && bus.recv_pix_rdy) begin
                cur_buf[cur_n] = bus.recv_pix;
                cur_n++;
                if (cur_n == NPIX) begin
                    if (m_have_prev)
                        for (int k = 0; k < NPIX; k++)
                            pq.push_back('{c: cur_buf[k], p: prev_frame[k]});
                    prev_frame = cur_buf;
                    m_have_prev = 1'b1;
                    cur_n = 0;
                end
            end
        end
    end

    initial begin
        bus.send_curr_rdy = 1'b1;
        bus.send_prev_rdy = 1'b1;
        bus.send_uv_rdy   = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rand_en) begin
                bus.send_curr_rdy = ($urandom_range(3) != 0);
                bus.send_prev_rdy = ($urandom_range(3) != 0);
                bus.send_uv_rdy   = ($urandom_range(3) != 0);
            end else begin
                bus.send_curr_rdy = 1'b1;
                bus.send_prev_rdy = 1'b1;
                bus.send_uv_rdy   = 1'b1;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic push_frame(input logic [7:0] base);
        for (int i = 0; i < NPIX; i++) begin
            bit acc = 1'b0;
            int w = 0;
            bus.recv_pix     = base + 8'(i);
            bus.recv_pix_val = 1'b1;
            while (!acc && w < 100) begin
                @(negedge clk);
                acc = bus.recv_pix_rdy;
                @(posedge clk); #1;
                w++;
            end
            check_eq("pix_accept", acc, 1'b1);
            if (!acc) break;
        end
        bus.recv_pix_val = 1'b0;
    endtask

    task automatic send_vectors(input int n, input logic [63:0] base, input int last_idx);
        for (int k = 0; k < n; k++) begin
            bit done = 1'b0;
            int w = 0;
            bus.recv_uv     = base + 64'(k);
            bus.recv_uv_val = 1'b1;
            while (!done && w < 200) begin
                @(negedge clk);
                if (bus.send_uv_rdy) begin
                    check_eq("uv_out_data", bus.send_uv, base + 64'(k));
                    check_eq("uv_last", bus.send_uv_last, (k == last_idx));
                    done = 1'b1;
                end
                @(posedge clk); #1;
                w++;
            end
            check_eq("uv_accept", done, 1'b1);
        end
        bus.recv_uv_val = 1'b0;
    endtask

    task automatic wait_frame_done(input int exp_cnt, input bit exp_err, input int exp_drain);
        bit seen = 1'b0;
        int w = 0;
        while (!seen && w < 300) begin
            @(negedge clk);
            seen = frame_done;
            w++;
        end
        check_eq("frame_done_seen", seen, 1'b1);
        @(negedge clk);
        check_eq("frame_done_one_cycle", frame_done, 1'b0);
        check_eq("frame_cnt", frame_cnt, 64'(exp_cnt));
        check_eq("err", err, exp_err);
        check_eq("busy_after_done", busy, 1'b0);
        if (exp_drain >= 0) check_eq("drain_cycles", drain_cyc, 64'(exp_drain));
        @(posedge clk); #1;
    endtask

    task automatic expect_first_pair(input logic [7:0] c, input logic [7:0] p);
        @(negedge clk);
        check_eq("first_val", bus.send_curr_val, 1'b1);
        check_eq("first_curr", bus.send_curr, c);
        check_eq("first_prev", bus.send_prev, p);
        @(posedge clk); #1;
    endtask

    initial begin
        bus.recv_pix     = '0;
        bus.recv_pix_val = 1'b0;
        bus.recv_uv      = '0;
        bus.recv_uv_val  = 1'b0;
        reset = 1'b1;

        // Reset state
        @(negedge clk);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_frame_cnt", frame_cnt, 16'd0);
        check_eq("rst_err", err, 1'b0);
        check_eq("rst_frame_done", frame_done, 1'b0);
        check_eq("rst_curr_val", bus.send_curr_val, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check_eq("pix_rdy_after_reset", bus.recv_pix_rdy, 1'b1);
        @(posedge clk); #1;

        // Frames A and B, eight vectors returned during STREAM
        push_frame(8'd0);
        push_frame(8'd16);
        expect_first_pair(8'd16, 8'd0);
        send_vectors(8, 64'h0000_0001_0000_1000, 7);
        wait_frame_done(1, 1'b0, 1);

        // Frame C under random backpressure
        push_frame(8'd32);
        expect_first_pair(8'd32, 8'd16);
        rand_en = 1'b1;
        send_vectors(8, 64'h0000_0002_0000_2000, 7);
        wait_frame_done(2, 1'b0, -1);
        rand_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Frame D, only five vectors: drain timeout
        push_frame(8'd48);
        expect_first_pair(8'd48, 8'd32);
        send_vectors(5, 64'h0000_0003_0000_3000, -1);
        wait_frame_done(3, 1'b1, DTO);

        // Stray vector in LOAD
        do_reset();
        @(negedge clk);
        check_eq("err_cleared", err, 1'b0);
        @(posedge clk); #1;
        send_vectors(1, 64'hDEAD_BEEF_0000_0004, -1);
        @(negedge clk);
        check_eq("err_load_vector", err, 1'b1);
        check_eq("busy_load_vector", busy, 1'b0);
        @(posedge clk); #1;

        // Reset in the middle of STREAM at rd_addr 7
        do_reset();
        push_frame(8'h40);
        push_frame(8'h50);
        repeat (7) @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check_eq("mid_curr", bus.send_curr, 8'h57);
        check_eq("mid_prev", bus.send_prev, 8'h47);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check_eq("mid_busy", busy, 1'b0);
        check_eq("mid_frame_cnt", frame_cnt, 16'd0);
        check_eq("mid_err", err, 1'b0);
        check_eq("mid_curr_val", bus.send_curr_val, 1'b0);
        @(posedge clk); #1;
        push_frame(8'h60);
        @(negedge clk);
        check_eq("no_stream_first_frame", busy, 1'b0);
        @(posedge clk); #1;
        push_frame(8'h70);
        expect_first_pair(8'h70, 8'h60);
        send_vectors(8, 64'h0000_0005_0000_5000, 7);
        wait_frame_done(1, 1'b0, 1);

        // Ninth vector: forwarded, flagged, not counted
        push_frame(8'h80);
        expect_first_pair(8'h80, 8'h70);
        send_vectors(9, 64'h0000_0006_0000_6000, 7);
        wait_frame_done(2, 1'b1, 1);

        check_eq("pairs_left", pq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
